// File: rtl/alu_control_muldiv_if.sv
// EX-stage bus between the ID/EX register and alu_control_muldiv: decode fields,
// operands, ALU control outputs, HI/LO read port and stall interlock.
interface alu_control_muldiv_if #(
  parameter int NBITS        = 32,
  parameter int ANBITS       = 6,
  parameter int NBITSCONTROL = 2,
  parameter int ALUOP        = 4
);
  logic                    i_valid;
  logic                    i_flush;
  logic [ANBITS-1:0]       i_Funct;
  logic [ANBITS-1:0]       i_Opcode;
  logic [NBITSCONTROL-1:0] i_ALUOp;
  logic [NBITS-1:0]        i_A;
  logic [NBITS-1:0]        i_B;

  logic [ALUOP-1:0]        o_ALUOp;
  logic                    o_Shamt;
  logic                    o_illegal;
  logic                    o_stall;
  logic                    o_hilo_sel;
  logic [NBITS-1:0]        o_hilo_data;
  logic                    o_busy;
  logic                    o_div_zero;

  modport master (
    output i_valid, i_flush, i_Funct, i_Opcode, i_ALUOp, i_A, i_B,
    input  o_ALUOp, o_Shamt, o_illegal, o_stall, o_hilo_sel, o_hilo_data,
           o_busy, o_div_zero
  );

  modport slave (
    input  i_valid, i_flush, i_Funct, i_Opcode, i_ALUOp, i_A, i_B,
    output o_ALUOp, o_Shamt, o_illegal, o_stall, o_hilo_sel, o_hilo_data,
           o_busy, o_div_zero
  );
endinterface

// File: rtl/alu_control_muldiv.sv
// MIPS EX-stage ALU control with an iterative HI/LO multiply/divide sequencer and stall
// interlock. Define ALU_CTRL_FAST_MULT_EN for a single-cycle registered multiplier.
module alu_control_muldiv #(
  parameter int NBITS        = 32,
  parameter int ANBITS       = 6,
  parameter int NBITSCONTROL = 2,
  parameter int ALUOP        = 4
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  alu_control_muldiv_if.slave bus
);

  localparam int              W2   = 2 * NBITS;
  localparam int              CW   = $clog2(NBITS);
  localparam logic [CW-1:0]   LAST = CW'(NBITS - 1);

  localparam logic [ALUOP-1:0] OP_AND = ALUOP'(4'b0000);
  localparam logic [ALUOP-1:0] OP_OR  = ALUOP'(4'b0001);
  localparam logic [ALUOP-1:0] OP_ADD = ALUOP'(4'b0010);
  localparam logic [ALUOP-1:0] OP_SLL = ALUOP'(4'b0011);
  localparam logic [ALUOP-1:0] OP_SRL = ALUOP'(4'b0100);
  localparam logic [ALUOP-1:0] OP_SRA = ALUOP'(4'b0101);
  localparam logic [ALUOP-1:0] OP_SUB = ALUOP'(4'b0110);
  localparam logic [ALUOP-1:0] OP_SLT = ALUOP'(4'b0111);
  localparam logic [ALUOP-1:0] OP_NOR = ALUOP'(4'b1100);
  localparam logic [ALUOP-1:0] OP_XOR = ALUOP'(4'b1101);
  localparam logic [ALUOP-1:0] OP_BAD = ALUOP'(4'b1111);

  localparam logic [ANBITS-1:0] F_SLL   = ANBITS'(6'b000000);
  localparam logic [ANBITS-1:0] F_SRL   = ANBITS'(6'b000010);
  localparam logic [ANBITS-1:0] F_SRA   = ANBITS'(6'b000011);
  localparam logic [ANBITS-1:0] F_SLLV  = ANBITS'(6'b000100);
  localparam logic [ANBITS-1:0] F_SRLV  = ANBITS'(6'b000110);
  localparam logic [ANBITS-1:0] F_SRAV  = ANBITS'(6'b000111);
  localparam logic [ANBITS-1:0] F_MFHI  = ANBITS'(6'b010000);
  localparam logic [ANBITS-1:0] F_MTHI  = ANBITS'(6'b010001);
  localparam logic [ANBITS-1:0] F_MFLO  = ANBITS'(6'b010010);
  localparam logic [ANBITS-1:0] F_MTLO  = ANBITS'(6'b010011);
  localparam logic [ANBITS-1:0] F_MULT  = ANBITS'(6'b011000);
  localparam logic [ANBITS-1:0] F_MULTU = ANBITS'(6'b011001);
  localparam logic [ANBITS-1:0] F_DIV   = ANBITS'(6'b011010);
  localparam logic [ANBITS-1:0] F_DIVU  = ANBITS'(6'b011011);
  localparam logic [ANBITS-1:0] F_ADD   = ANBITS'(6'b100000);
  localparam logic [ANBITS-1:0] F_ADDU  = ANBITS'(6'b100001);
  localparam logic [ANBITS-1:0] F_SUB   = ANBITS'(6'b100010);
  localparam logic [ANBITS-1:0] F_SUBU  = ANBITS'(6'b100011);
  localparam logic [ANBITS-1:0] F_AND   = ANBITS'(6'b100100);
  localparam logic [ANBITS-1:0] F_OR    = ANBITS'(6'b100101);
  localparam logic [ANBITS-1:0] F_XOR   = ANBITS'(6'b100110);
  localparam logic [ANBITS-1:0] F_NOR   = ANBITS'(6'b100111);
  localparam logic [ANBITS-1:0] F_SLT   = ANBITS'(6'b101010);

  localparam logic [ANBITS-1:0] OPC_SLTI = ANBITS'(6'b001010);
  localparam logic [ANBITS-1:0] OPC_ANDI = ANBITS'(6'b001100);
  localparam logic [ANBITS-1:0] OPC_ORI  = ANBITS'(6'b001101);
  localparam logic [ANBITS-1:0] OPC_XORI = ANBITS'(6'b001110);

  localparam logic [NBITSCONTROL-1:0] C_ADD = NBITSCONTROL'(2'b00);
  localparam logic [NBITSCONTROL-1:0] C_SUB = NBITSCONTROL'(2'b01);
  localparam logic [NBITSCONTROL-1:0] C_R   = NBITSCONTROL'(2'b10);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [W2-1:0]    acc_q;
  logic [NBITS-1:0] opnd_q;
  logic             neg_lo_q, neg_hi_q, is_div_q, dz_q;
  logic [NBITS-1:0] hi_q, lo_q;

  logic [ALUOP-1:0] alu_op;
  logic             illegal, stall;

  // ---------------------------------------------------------------- decode
  logic is_r;
  logic is_mult, is_multu, is_div, is_divu, is_mfhi, is_mthi, is_mflo, is_mtlo, is_mdu;

  assign is_r     = (bus.i_ALUOp == C_R);
  assign is_mult  = is_r && (bus.i_Funct == F_MULT);
  assign is_multu = is_r && (bus.i_Funct == F_MULTU);
  assign is_div   = is_r && (bus.i_Funct == F_DIV);
  assign is_divu  = is_r && (bus.i_Funct == F_DIVU);
  assign is_mfhi  = is_r && (bus.i_Funct == F_MFHI);
  assign is_mthi  = is_r && (bus.i_Funct == F_MTHI);
  assign is_mflo  = is_r && (bus.i_Funct == F_MFLO);
  assign is_mtlo  = is_r && (bus.i_Funct == F_MTLO);
  assign is_mdu   = is_mult | is_multu | is_div | is_divu |
                    is_mfhi | is_mthi | is_mflo | is_mtlo;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    alu_op  = OP_BAD;
    illegal = 1'b0;
    case (bus.i_ALUOp)
      C_ADD: alu_op = OP_ADD;
      C_SUB: alu_op = OP_SUB;
      C_R: begin
        case (bus.i_Funct)
          F_ADD, F_ADDU:   alu_op = OP_ADD;
          F_SUB, F_SUBU:   alu_op = OP_SUB;
          F_AND:           alu_op = OP_AND;
          F_OR:            alu_op = OP_OR;
          F_NOR:           alu_op = OP_NOR;
          F_XOR:           alu_op = OP_XOR;
          F_SLT:           alu_op = OP_SLT;
          F_SLL, F_SLLV:   alu_op = OP_SLL;
          F_SRL, F_SRLV:   alu_op = OP_SRL;
          F_SRA, F_SRAV:   alu_op = OP_SRA;
          F_MULT, F_MULTU, F_DIV, F_DIVU,
          F_MFHI, F_MTHI, F_MFLO, F_MTLO: alu_op = OP_BAD;
          default:         illegal = 1'b1;
        endcase
      end
      default: begin
        case (bus.i_Opcode)
          OPC_ANDI: alu_op = OP_AND;
          OPC_ORI:  alu_op = OP_OR;
          OPC_XORI: alu_op = OP_XOR;
          OPC_SLTI: alu_op = OP_SLT;
          default:  illegal = 1'b1;
        endcase
      end
    endcase
  end

  // ------------------------------------------------------- operand prep
  logic             start_mul, start_div, op_signed, a_neg, b_neg;
  logic [NBITS-1:0] a_mag, b_mag;

  assign start_mul = (state_q == S_IDLE) && bus.i_valid && !bus.i_flush && (is_mult || is_multu);
  assign start_div = (state_q == S_IDLE) && bus.i_valid && !bus.i_flush && (is_div || is_divu);
  assign op_signed = is_mult || is_div;
  assign a_neg     = op_signed && bus.i_A[NBITS-1];
  assign b_neg     = op_signed && bus.i_B[NBITS-1];
  assign a_mag     = a_neg ? -bus.i_A : bus.i_A;
  assign b_mag     = b_neg ? -bus.i_B : bus.i_B;

  // ------------------------------------------------------ iteration steps
`ifndef ALU_CTRL_FAST_MULT_EN
  logic [NBITS:0]  mul_sum;
  logic [W2-1:0]   mul_next;
  // Shift-add: low half holds the remaining multiplier bits, high half the partial product.
  assign mul_sum  = {1'b0, acc_q[W2-1:NBITS]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[NBITS-1:1]} : {1'b0, acc_q[W2-1:1]};
`endif

  logic [NBITS:0]  div_rsh, div_diff;
  logic [W2-1:0]   div_next;
  // Restoring divide: high half is the running remainder, low half shifts dividend out
  // and quotient bits in; a borrow in div_diff means the trial subtraction is discarded.
  assign div_rsh  = acc_q[W2-1:NBITS-1];
  assign div_diff = div_rsh - {1'b0, opnd_q};
  assign div_next = div_diff[NBITS] ? {div_rsh[NBITS-1:0], acc_q[NBITS-2:0], 1'b0}
                                    : {div_diff[NBITS-1:0], acc_q[NBITS-2:0], 1'b1};

  // ----------------------------------------------------- sign correction
  logic [W2-1:0]    prod;
  logic [NBITS-1:0] q_mag, r_mag, res_hi, res_lo;

  assign prod   = neg_lo_q ? -acc_q : acc_q;
  assign q_mag  = acc_q[NBITS-1:0];
  assign r_mag  = acc_q[W2-1:NBITS];
  assign res_lo = is_div_q ? (dz_q ? '1 : (neg_lo_q ? -q_mag : q_mag)) : prod[NBITS-1:0];
  assign res_hi = is_div_q ? (neg_hi_q ? -r_mag : r_mag) : prod[W2-1:NBITS];

  // --------------------------------------------------------------- FSM
  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_mul) begin
          state_d = S_MUL;
          stall   = 1'b1;
        end else if (start_div) begin
          state_d = S_DIV;
          stall   = 1'b1;
        end
      end
      S_MUL: begin
        stall = 1'b1;
`ifdef ALU_CTRL_FAST_MULT_EN
        state_d = S_DONE;
`else
        if (cnt_q == LAST) state_d = S_DONE;
`endif
      end
      S_DIV: begin
        stall = 1'b1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
    endcase
    // A HI/LO consumer arriving while the sequencer is busy waits in EX.
    if (state_q != S_IDLE && bus.i_valid && is_mdu) stall = 1'b1;
    if (bus.i_flush) begin
      state_d = S_IDLE;
      stall   = 1'b0;
    end
  end

  // ------------------------------------------------------------ datapath
  // NOTE: the working registers are reset too so a fresh start never sees stale flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_mul || start_div) begin
            cnt_q    <= '0;
            opnd_q   <= start_mul ? a_mag : b_mag;
            acc_q    <= {{NBITS{1'b0}}, (start_mul ? b_mag : a_mag)};
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= start_mul ? (a_neg ^ b_neg) : a_neg;
            is_div_q <= start_div;
            dz_q     <= start_div && (bus.i_B == '0);
          end
        end
        S_MUL: begin
`ifdef ALU_CTRL_FAST_MULT_EN
          acc_q <= W2'(opnd_q) * W2'(acc_q[NBITS-1:0]);
`else
          acc_q <= mul_next;
          cnt_q <= cnt_q + 1'b1;
`endif
        end
        S_DIV: begin
          acc_q <= div_next;
          cnt_q <= cnt_q + 1'b1;
        end
        S_DONE: cnt_q <= '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == S_DONE && !bus.i_flush) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (state_q == S_IDLE && bus.i_valid && !bus.i_flush) begin
      if (is_mthi) hi_q <= bus.i_A;
      if (is_mtlo) lo_q <= bus.i_A;
    end
  end

  // -------------------------------------------------------------- outputs
  logic hilo_sel;
  assign hilo_sel = i_rst_n && (state_q == S_IDLE) && bus.i_valid && (is_mfhi || is_mflo);

  assign bus.o_ALUOp     = alu_op;
  assign bus.o_Shamt     = i_rst_n && is_r &&
                           (bus.i_Funct == F_SLL || bus.i_Funct == F_SRL || bus.i_Funct == F_SRA);
  assign bus.o_illegal   = i_rst_n && illegal;
  assign bus.o_stall     = i_rst_n && stall;
  assign bus.o_busy      = (state_q != S_IDLE);
  assign bus.o_hilo_sel  = hilo_sel;
  assign bus.o_hilo_data = hilo_sel ? (is_mfhi ? hi_q : lo_q) : '0;
  assign bus.o_div_zero  = (state_q == S_DONE) && is_div_q && dz_q;

endmodule
